seq_ctrl: RTL and testbench

//  Multi-cycle instruction sequencer for the RISC-V core: FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/seq_timer.sv | 39 +++
 rtl/seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the multi-cycle instruction sequencer.
// State encoding, major opcodes and instruction classes.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IC_ALU,
    IC_LOAD,
    IC_STORE,
    IC_SYS,
    IC_BAD
  } iclass_t;

  function automatic iclass_t classify(input logic [6:0] opc);
    iclass_t c;
    unique case (1'b1)
      (opc == OPC_LOAD):   c = IC_LOAD;
      (opc == OPC_STORE):  c = IC_STORE;
      (opc == OPC_OP),
      (opc == OPC_OPIMM),
      (opc == OPC_LUI):    c = IC_ALU;
      (opc == OPC_SYSTEM): c = IC_SYS;
      default:             c = IC_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: counts waiting cycles of a memory handshake.
// expired_o flags the TIMEOUT-th waiting cycle.
module seq_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic nreset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of waiting cycles already elapsed
  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeouts.
// Define SEQ_INSTRET_EN to add the retired-instruction counter port.
module seq_ctrl
  import riscv_pkg::*;
#(
  parameter int olen    = 7,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            run,
  input  logic [olen-1:0] opcode,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  output logic            imem_req,
  output logic            ir_load,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            incr,
  output logic            rf_we,
  output logic [2:0]      state,
  output logic            halted,
  output logic            fault
`ifdef SEQ_INSTRET_EN
  ,
  output logic [31:0]     instret
`endif
);

  state_t  state_q, state_d;
  iclass_t cls_q, cls_d;

  logic waiting;
  logic tmr_clear;
  logic tmr_exp;

  assign waiting   = (state_q == ST_FETCH) ||
                     (state_q == ST_MEM);
  // restart the count on every state change
  assign tmr_clear = !waiting ||
                     (state_d != state_q);

  seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .nreset    (nreset),
    .clear_i   (tmr_clear),
    .en_i      (waiting),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    incr     = 1'b0;
    rf_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (tmr_exp) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        cls_d   = classify(opcode[6:0]);
        state_d = (cls_d == IC_BAD) ? ST_FAULT
                                    : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          IC_LOAD,
          IC_STORE: state_d = ST_MEM;
          IC_SYS:   state_d = ST_HALT;
          IC_ALU:   state_d = ST_WB;
          default:  state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == IC_STORE);
        if (dmem_ack) begin
          if (cls_q == IC_STORE) begin
            incr    = 1'b1;
            state_d = run ? ST_FETCH : ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmr_exp) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        incr    = 1'b1;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT,
      ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cls_q   <= IC_ALU;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);
  assign fault  = (state_q == ST_FAULT);

`ifdef SEQ_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      instret_q <= '0;
    end else if (incr) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed and random instruction streams against a
// per-instruction cycle-trace model of the sequencer.
module tb_seq_ctrl;

  localparam int TO = 15;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] SYS   = 7'b1110011;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       run = 1'b0;
  logic [6:0] opcode = '0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, ir_load, dmem_req, dmem_we;
  logic       incr, rf_we, halted, fault;
  logic [2:0] state;
`ifdef SEQ_INSTRET_EN
  logic [31:0] instret;
`endif

  seq_ctrl #(
    .olen    (7),
    .TIMEOUT (TO)
  ) dut (
    .clock    (clock),
    .nreset   (nreset),
    .run      (run),
    .opcode   (opcode),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .imem_req (imem_req),
    .ir_load  (ir_load),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .incr     (incr),
    .rf_we    (rf_we),
    .state    (state),
    .halted   (halted),
    .fault    (fault)
`ifdef SEQ_INSTRET_EN
    ,
    .instret  (instret)
`endif
  );

  always #5 clock = ~clock;

  // expected vector: {state, imr, irl, dmr, dwe, inc, rfw, hlt, flt}
  typedef struct packed {
    logic        r;
    logic [6:0]  o;
    logic        ia;
    logic        da;
    logic [10:0] e;
  } cyc_t;

  cyc_t        plan[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          idle_m = 1'b1;
  logic [31:0] ret_m = '0;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic [10:0] ev(input logic [2:0] st,
                                     input logic [7:0] f);
    return {st, f};
  endfunction

  // 0 alu, 1 load, 2 store, 3 system, 4 illegal
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      LOAD:             return 1;
      STORE:            return 2;
      OP, OPIMM, LUI:   return 0;
      SYS:              return 3;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [10:0] outv();
    return {state, imem_req, ir_load, dmem_req, dmem_we,
            incr, rf_we, halted, fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic [6:0] o,
                      input logic a_i, input logic a_d,
                      input logic [10:0] e);
    cyc_t c;
    c.r = r; c.o = o; c.ia = a_i; c.da = a_d; c.e = e;
    plan.push_back(c);
  endtask

  // Builds the cycle trace of one instruction; term = 6/7 when it
  // ends the stream in HALT/FAULT, else 0.
  task automatic gen_instr(input logic [6:0] opc, input int fd,
                           input int md, input bit rn,
                           output int term);
    int  cls;
    bit  st;
    term = 0;
    cls  = cls_of(opc);
    st   = (cls == 2);
    if (idle_m) begin
      repeat ($urandom_range(0, 2))
        push(1'b0, rop(), rb(), rb(), ev(3'd0, 8'b0));
      push(1'b1, rop(), rb(), rb(), ev(3'd0, 8'b0));
      idle_m = 1'b0;
    end
    for (int i = 0; i < fd && i < TO; i++)
      push(rb(), rop(), 1'b0, rb(), ev(3'd1, 8'b1000_0000));
    if (fd >= TO) begin term = 7; return; end
    push(rb(), rop(), 1'b1, rb(), ev(3'd1, 8'b1100_0000));
    push(rb(), opc, rb(), rb(), ev(3'd2, 8'b0));
    if (cls == 4) begin term = 7; return; end
    push(rb(), opc, rb(), rb(), ev(3'd3, 8'b0));
    if (cls == 3) begin term = 6; return; end
    if (cls == 1 || cls == 2) begin
      for (int i = 0; i < md && i < TO; i++)
        push(rb(), opc, rb(), 1'b0,
             ev(3'd4, {2'b00, 1'b1, st, 4'b0}));
      if (md >= TO) begin term = 7; return; end
      push(st ? logic'(rn) : logic'(rb()), opc, rb(), 1'b1,
           ev(3'd4, {2'b00, 1'b1, st, st, 3'b0}));
      if (st) begin idle_m = !rn; return; end
    end
    push(rn, opc, rb(), rb(), ev(3'd5, 8'b0000_1100));
    idle_m = !rn;
  endtask

  task automatic exec_plan(input string tag);
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge clock);
      run = c.r; opcode = c.o;
      imem_ack = c.ia; dmem_ack = c.da;
      #1;
      check(tag, 32'(outv()), 32'(c.e));
`ifdef SEQ_INSTRET_EN
      check({tag, "_instret"}, instret, ret_m);
`endif
      if (c.e[3]) ret_m = ret_m + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 nreset = 1'b0;
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1 check("rst_async", 32'(outv()), 32'd0);
    @(negedge clock);
    #1 check("rst_hold", 32'(outv()), 32'd0);
`ifdef SEQ_INSTRET_EN
    check("rst_instret", instret, 32'd0);
`endif
    nreset = 1'b1;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    ret_m  = '0;
    idle_m = 1'b1;
  endtask

  task automatic instr(input string tag, input logic [6:0] opc,
                       input int fd, input int md, input bit rn);
    int term;
    gen_instr(opc, fd, md, rn, term);
    if (term != 0) begin
      repeat (6)
        push(rb(), rop(), rb(), rb(),
             ev(3'(term), (term == 6) ? 8'b10 : 8'b01));
    end
    exec_plan(tag);
    if (term != 0) do_reset();
  endtask

  logic [6:0] optab[6];

  initial begin
    optab[0] = LOAD; optab[1] = STORE; optab[2] = OP;
    optab[3] = OPIMM; optab[4] = LUI; optab[5] = SYS;

    repeat (2) @(negedge clock);
    #1 check("reset", 32'(outv()), 32'd0);
    nreset = 1'b1;

    // reset while a fetch is outstanding
    push(1'b1, rop(), 1'b0, 1'b0, ev(3'd0, 8'b0));
    repeat (3)
      push(1'b1, rop(), 1'b0, 1'b0, ev(3'd1, 8'b1000_0000));
    exec_plan("fetch_pre_rst");
    idle_m = 1'b0;
    do_reset();

    instr("alu0", OP, 0, 0, 1'b1);
    instr("alu1", OP, 0, 0, 1'b1);
    instr("alu2", OPIMM, 1, 0, 1'b1);
    instr("lui", LUI, 0, 0, 1'b0);
    instr("load", LOAD, 0, 3, 1'b1);
    instr("store", STORE, 0, 3, 1'b1);
    instr("store0", STORE, 0, 0, 1'b0);
    instr("load0", LOAD, 2, 0, 1'b0);

    instr("fetch_last", OP, TO - 1, 0, 1'b1);
    instr("mem_last", LOAD, 0, TO - 1, 1'b1);
    instr("fetch_to", OP, TO, 0, 1'b1);
    instr("mem_to", STORE, 0, TO, 1'b1);
    instr("bad_op", 7'b1111111, 0, 0, 1'b1);
    instr("halt", SYS, 0, 0, 1'b1);
    instr("post_halt", OP, 0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [6:0] o;
      int fd, md, sel;
      sel = int'($urandom_range(0, 19));
      o   = (sel < 18) ? optab[sel % 5]
                       : ((sel == 18) ? SYS : rop());
      fd  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16))
                                        : int'($urandom_range(0, 3));
      md  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16))
                                        : int'($urandom_range(0, 3));
      instr("rand", o, fd, md, rb());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
